// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// registered in_ready, flush-to-bubble and a saturating downstream-stall counter.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned PAYLOAD_W = NUM_CH * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [PAYLOAD_W-1:0] main_q, main_nxt;
  logic [PAYLOAD_W-1:0] skid_q, skid_nxt;
  logic                 acc, snd;

  // in_ready/out_valid are flops that always mirror the state register
  assign acc      = in_valid && in_ready;
  assign snd      = out_valid && out_ready;
  assign out_data = main_q;

  // Next-state and storage update
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (acc && snd) begin
          main_nxt = in_data;
        end else if (acc) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (snd) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (snd) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops everything, including a word offered this cycle, and leaves a NOP bubble
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end
  end

  // State, storage and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= 2'(state_nxt);
    end
  end

  // Saturating count of cycles where downstream back-pressures a valid word
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus randomized
// traffic checked against a queue-based model of the stage contents.
module tb_pipe_skid_stage;

  localparam int unsigned W     = 128;
  localparam int          M_MAX = 65535;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  // Small instance for counter saturation and channel packing
  logic         s_reset, s_flush, s_in_valid, s_out_ready;
  logic         s_in_ready, s_out_valid;
  logic [15:0]  s_in_data, s_out_data;
  logic [1:0]   s_occupancy;
  logic [3:0]   s_stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  int           m_stall;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(8), .NUM_CH(2), .CNT_W(4)) dut_s (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] all_ch(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  // One clock of the main DUT: drive inputs, advance the model, compare after the edge
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    bit acc, snd;
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    if (r) begin
      mq.delete();
      m_last  = '0;
      m_stall = 0;
    end else begin
      acc = iv && (mq.size() < 2);
      snd = (mq.size() > 0) && ordy;
      if ((mq.size() > 0) && !ordy && (m_stall < M_MAX)) m_stall++;
      if (f) begin
        mq.delete();
        m_last = '0;
      end else begin
        if (snd) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        if (mq.size() > 0) m_last = mq[0];
      end
    end
    @(posedge clk);
    #1;
    check("in_ready",  W'(in_ready),  W'(mq.size() < 2));
    check("out_valid", W'(out_valid), W'(mq.size() > 0));
    check("occupancy", W'(occupancy), W'(mq.size()));
    check("stall_cnt", W'(stall_cnt), W'(m_stall));
    check("out_data",  out_data,      m_last);
  endtask

  task automatic s_step(input logic r, input logic iv, input logic [15:0] d, input logic ordy);
    s_reset = r; s_flush = 1'b0; s_in_valid = iv; s_in_data = d; s_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ch0, ch1;
    int         exp_sat;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    m_last = '0; m_stall = 0;

    // Reset state
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);

    // Streaming with out_ready high
    step(0, 0, 1, all_ch(32'h11), 1);
    step(0, 0, 1, all_ch(32'h22), 1);
    step(0, 0, 1, all_ch(32'h33), 1);
    step(0, 0, 0, '0, 1);

    // Back-pressure fills the skid, then drains in order
    step(0, 0, 1, all_ch(32'hA), 0);
    step(0, 0, 1, all_ch(32'hB), 0);
    step(0, 0, 1, all_ch(32'hD), 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Flush while full, with a word offered in the flush cycle
    step(0, 0, 1, all_ch(32'h1), 0);
    step(0, 0, 1, all_ch(32'h2), 0);
    step(0, 1, 1, all_ch(32'hC), 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Reset together with flush mid-stream
    step(0, 0, 1, all_ch(32'h5), 0);
    step(0, 0, 1, all_ch(32'h6), 0);
    step(1, 1, 1, all_ch(32'h7), 0);
    step(0, 0, 0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 9) < 5));
    end

    // Saturation on a 4-bit counter
    s_step(1, 0, '0, 0);
    s_step(0, 1, 16'hBEEF, 0);
    check("s_stall_start", W'(s_stall_cnt), W'(0));
    ch0 = s_out_data[7:0];
    ch1 = s_out_data[15:8];
    check("s_ch0", W'(ch0), W'(8'hEF));
    check("s_ch1", W'(ch1), W'(8'hBE));
    for (int k = 1; k <= 20; k++) begin
      s_step(0, 0, '0, 0);
      exp_sat = (k > 15) ? 15 : k;
      check("s_stall_sat", W'(s_stall_cnt), W'(exp_sat));
    end
    check("s_hold_data", W'(s_out_data), W'(16'hBEEF));
    s_step(1, 0, '0, 0);
    check("s_stall_reset", W'(s_stall_cnt), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
